// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds the fetch FSM encoding and the sequential PC step.
package inst_prefetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with push, pop, clear and occupancy.
// Pointers are PW bits wide, so they wrap mod DEPTH on their own.
module inst_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i & ~clear_i;
        do_pop  = pop_i & ~clear_i & (count_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the head is only observed when count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential ROM fetch over req/ack, buffered in a
// small FIFO and handed to IF_ID with valid/ready; flush redirects fetch.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_chipEnable,
    output logic              o_romReq,
    output logic [ADDR_W-1:0] o_romAddr,
    input  logic              i_romAck,
    input  logic [INST_W-1:0] i_romInst,
    output logic              o_instValid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_instPc,
    input  logic              i_instReady,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flushPc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = ADDR_W + INST_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   drain_pc_q, drain_pc_d;
    logic                ce_q;
    logic [CW-1:0]       count;
    logic [FW-1:0]       head;
    logic [CW:0]         cnt_after;
    logic                req, active, push, pop, inst_valid;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & i_instReady & ~i_flush;

    always_comb begin
        req        = 1'b0;
        active     = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            S_IDLE: begin
                // No request while redirecting: it would carry the stale PC.
                req    = ce_q & (count < CW'(DEPTH)) & ~i_flush;
                active = req;
            end
            S_WAIT: begin
                req    = 1'b1;
                active = 1'b1;
            end
            S_DRAIN: req = 1'b1;
            default: ;
        endcase

        push      = active & i_romAck & ~i_flush;
        cnt_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

        if (state_q == S_DRAIN) begin
            state_d = i_romAck ? S_IDLE : S_DRAIN;
        end else if (active) begin
            if (i_flush)       state_d = i_romAck ? S_IDLE : S_DRAIN;
            else if (i_romAck) state_d = (cnt_after < (CW+1)'(DEPTH)) ? S_WAIT : S_IDLE;
            else               state_d = S_WAIT;
        end else begin
            state_d = S_IDLE;
        end

        drain_pc_d = (active & i_flush & ~i_romAck) ? fetch_pc_q : drain_pc_q;

        fetch_pc_d = fetch_pc_q;
        if (i_flush)   fetch_pc_d = i_flushPc;
        else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
            ce_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drain_pc_q <= drain_pc_d;
            ce_q       <= 1'b1;
        end
    end

    inst_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (i_flush),
        .data_i  ({fetch_pc_q, i_romInst}),
        .data_o  (head),
        .count_o (count)
    );

    assign o_chipEnable       = ce_q;
    assign o_romReq           = req;
    assign o_romAddr          = (state_q == S_DRAIN) ? drain_pc_q : fetch_pc_q;
    assign o_instValid        = inst_valid;
    assign {o_instPc, o_inst} = inst_valid ? head : '0;

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: directed cycle table, mid-op reset, and
// randomized ROM latency / backpressure / flush against a stream model.
module tb_inst_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_chipEnable;
    logic        o_romReq;
    logic [31:0] o_romAddr;
    logic        i_romAck = 1'b0;
    logic [31:0] i_romInst = '0;
    logic        o_instValid;
    logic [31:0] o_inst;
    logic [31:0] o_instPc;
    logic        i_instReady = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_flushPc = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int waitcnt = 0;

    always #5 clk = ~clk;

    inst_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .o_chipEnable (o_chipEnable),
        .o_romReq     (o_romReq),
        .o_romAddr    (o_romAddr),
        .i_romAck     (i_romAck),
        .i_romInst    (i_romInst),
        .o_instValid  (o_instValid),
        .o_inst       (o_inst),
        .o_instPc     (o_instPc),
        .i_instReady  (i_instReady),
        .i_flush      (i_flush),
        .i_flushPc    (i_flushPc)
    );

    typedef struct {
        logic        rdy;
        logic        fl;
        logic [31:0] fpc;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] pc;
    } vec_t;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic vec_t mkv(input logic r, input logic f, input logic [31:0] fp,
                                 input int lat, input logic rq, input logic [31:0] ad,
                                 input logic vl, input logic [31:0] pc);
        vec_t t;
        t.rdy = r; t.fl = f; t.fpc = fp; t.lat = lat;
        t.req = rq; t.addr = ad; t.val = vl; t.pc = pc;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ROM model: acks once the request has been held for 'lat' cycles.
    task automatic step(input logic r, input logic f, input logic [31:0] fp, input int lat);
        @(negedge clk);
        i_instReady = r;
        i_flush     = f;
        i_flushPc   = fp;
        i_romAck    = 1'b0;
        i_romInst   = '0;
        #1;
        if (o_romReq && waitcnt >= lat) begin
            i_romAck  = 1'b1;
            i_romInst = rom(o_romAddr);
        end
        #1;
        if (o_romReq && !i_romAck) waitcnt++;
        else waitcnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vq[$];
        logic [31:0] exp_pc;
        logic        chk_inv;
        logic        prev_req, prev_ack;
        logic [31:0] prev_addr;
        logic        fl, rdy;
        logic [31:0] fpc;
        int          lat, ncons;

        //        rdy fl fpc          lat req addr         val pc
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h0,        0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h4,        1, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h8,        1, 32'h4));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'hC,        1, 32'h8));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'h10,       1, 32'hC));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'h14,       1, 32'hC));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'h18,       1, 32'hC));
        vq.push_back(mkv(0, 0, 32'h0, 0, 0, 32'h1C,       1, 32'hC));
        vq.push_back(mkv(1, 0, 32'h0, 0, 0, 32'h1C,       1, 32'hC));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'h1C,       1, 32'h10));
        vq.push_back(mkv(0, 0, 32'h0, 0, 0, 32'h20,       1, 32'h10));
        vq.push_back(mkv(1, 1, 32'h80, 0, 0, 32'h20,      1, 32'h10));
        vq.push_back(mkv(1, 0, 32'h0, 3, 1, 32'h80,       0, 32'h0));
        vq.push_back(mkv(1, 1, 32'h100, 3, 1, 32'h80,     0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 3, 1, 32'h80,       0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 3, 1, 32'h80,       0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h100,      0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h104,      1, 32'h100));
        vq.push_back(mkv(1, 1, 32'h40, 0, 1, 32'h108,     1, 32'h104));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h40,       0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h44,       1, 32'h40));
        vq.push_back(mkv(1, 1, 32'hFFFFFFFC, 0, 1, 32'h48, 1, 32'h44));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'hFFFFFFFC, 0, 32'h0));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h0,        1, 32'hFFFFFFFC));
        vq.push_back(mkv(1, 0, 32'h0, 0, 1, 32'h4,        1, 32'h0));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'h8,        1, 32'h4));
        vq.push_back(mkv(0, 0, 32'h0, 0, 1, 32'hC,        1, 32'h4));
        vq.push_back(mkv(0, 0, 32'h0, 3, 1, 32'h10,       1, 32'h4));

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ce",    32'(o_chipEnable), 32'h0);
        check("rst_req",   32'(o_romReq),     32'h0);
        check("rst_addr",  o_romAddr,         32'h0);
        check("rst_valid", 32'(o_instValid),  32'h0);
        check("rst_inst",  o_inst,            32'h0);
        check("rst_pc",    o_instPc,          32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].rdy, vq[i].fl, vq[i].fpc, vq[i].lat);
            if (i == 0) check("v0_ce", 32'(o_chipEnable), 32'h1);
            check($sformatf("v%0d_req", i),   32'(o_romReq),    32'(vq[i].req));
            check($sformatf("v%0d_addr", i),  o_romAddr,        vq[i].addr);
            check($sformatf("v%0d_valid", i), 32'(o_instValid), 32'(vq[i].val));
            check($sformatf("v%0d_pc", i),    o_instPc,         vq[i].pc);
            check($sformatf("v%0d_inst", i),  o_inst,           vq[i].val ? rom(vq[i].pc) : 32'h0);
        end

        // Mid-operation reset: three buffered words and a request in flight.
        #1;
        rst       = 1'b1;
        i_romAck  = 1'b0;
        i_flush   = 1'b0;
        waitcnt   = 0;
        #1;
        check("mrst_ce",    32'(o_chipEnable), 32'h0);
        check("mrst_req",   32'(o_romReq),     32'h0);
        check("mrst_addr",  o_romAddr,         32'h0);
        check("mrst_valid", 32'(o_instValid),  32'h0);
        check("mrst_inst",  o_inst,            32'h0);
        check("mrst_pc",    o_instPc,          32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 32'h0, 0);
        check("rs1_req",   32'(o_romReq),    32'h1);
        check("rs1_addr",  o_romAddr,        32'h0);
        check("rs1_valid", 32'(o_instValid), 32'h0);
        step(1, 0, 32'h0, 0);
        check("rs2_valid", 32'(o_instValid), 32'h1);
        check("rs2_pc",    o_instPc,         32'h0);
        check("rs2_addr",  o_romAddr,        32'h4);

        // Randomized run against the in-order fetch-stream model.
        exp_pc   = 32'h1000;
        chk_inv  = 1'b1;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        ncons    = 0;
        step(1, 1, 32'h1000, 0);
        prev_req  = o_romReq;
        prev_ack  = i_romAck;
        prev_addr = o_romAddr;
        for (int c = 0; c < 1500; c++) begin
            fl  = ($urandom_range(0, 19) == 0);
            fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
            rdy = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(0, 3);
            step(rdy, fl, fpc, lat);
            if (chk_inv) check("flush_valid", 32'(o_instValid), 32'h0);
            if (prev_req && !prev_ack) begin
                check("hold_req",  32'(o_romReq), 32'h1);
                check("hold_addr", o_romAddr,     prev_addr);
            end
            if (o_instValid && rdy && !fl) begin
                check("stream_pc",   o_instPc, exp_pc);
                check("stream_inst", o_inst,   rom(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (fl) exp_pc = fpc;
            chk_inv   = fl;
            prev_req  = o_romReq;
            prev_ack  = i_romAck;
            prev_addr = o_romAddr;
        end
        check("progress", 32'(ncons > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
